rr_arbiter6: RTL and testbench



---
 rtl/rr_arbiter6.sv | 105 ++++++++++
 tb/tb_rr_arbiter6.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter6.sv
// Six-way round-robin arbiter with a hold limit. A grant ends on done, when the owner
// drops its request, or when the hold limit forces it off. Each release leaves one idle cycle.
module rr_arbiter6 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [5:0]       req,
    input  logic             done,
    output logic [5:0]       gnt,
    output logic [2:0]       gnt_id,
    output logic             gnt_vld,
    output logic             timeout,
    output logic [CNT_W-1:0] hold_cnt
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [2:0]       last_q, last_d;
    logic [5:0]       gnt_q, gnt_d;
    logic [2:0]       gnt_id_q, gnt_id_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             win_found;
    logic [2:0]       win_id;
    logic [3:0]       cand;

    // Search begins one position past the previous owner and wraps modulo 6.
    always_comb begin
        win_found = 1'b0;
        win_id    = 3'd0;
        cand      = 4'd0;
        for (int i = 1; i <= 6; i++) begin
            cand = {1'b0, last_q} + 4'(i);
            if (cand >= 4'd6) cand = cand - 4'd6;
            if (!win_found && req[cand[2:0]]) begin
                win_found = 1'b1;
                win_id    = cand[2:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d  = GRANT;
                    gnt_d    = 6'b000001 << win_id;
                    gnt_id_d = win_id;
                    cnt_d    = '0;
                end
            end
            GRANT: begin
                if (done || !req[gnt_id_q] || cnt_q == HOLD_LAST) begin
                    // A voluntary release never raises timeout, even on the final cycle.
                    timeout_d = !(done || !req[gnt_id_q]);
                    state_d   = IDLE;
                    last_d    = gnt_id_q;
                    gnt_d     = '0;
                    gnt_id_d  = '0;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            last_q    <= 3'd5;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt      = gnt_q;
    assign gnt_id   = gnt_id_q;
    assign gnt_vld  = (state_q == GRANT);
    assign timeout  = timeout_q;
    assign hold_cnt = cnt_q;

endmodule

// File: tb/tb_rr_arbiter6.sv
// Bench for rr_arbiter6: directed scenarios plus random traffic against a behavioural owner/pointer model.
module tb_rr_arbiter6;

    localparam int MAX_HOLD = 8;
    localparam int CNT_W    = 8;

    logic             clk = 1'b0;
    logic             rst_b;
    logic [5:0]       req;
    logic             done;
    logic [5:0]       gnt;
    logic [2:0]       gnt_id;
    logic             gnt_vld;
    logic             timeout;
    logic [CNT_W-1:0] hold_cnt;

    int vectors = 0;
    int errs    = 0;

    // Model: owner index (-1 when free), cycles held, last owner, pending timeout flag.
    int m_own, m_cnt, m_last, m_to;

    rr_arbiter6 #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_b(rst_b), .req(req), .done(done),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_vld(gnt_vld),
        .timeout(timeout), .hold_cnt(hold_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own = -1; m_cnt = 0; m_last = 5; m_to = 0;
    endtask

    task automatic model_update();
        if (m_own < 0) begin
            m_to = 0;
            for (int i = 1; i <= 6; i++) begin
                int k;
                k = (m_last + i) % 6;
                if (m_own < 0 && req[k]) m_own = k;
            end
            m_cnt = 0;
        end else if (done || !req[m_own]) begin
            m_last = m_own; m_own = -1; m_cnt = 0; m_to = 0;
        end else if (m_cnt == MAX_HOLD - 1) begin
            m_last = m_own; m_own = -1; m_cnt = 0; m_to = 1;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic check_all();
        chk("gnt",      int'(gnt),      (m_own >= 0) ? (1 << m_own) : 0);
        chk("gnt_id",   int'(gnt_id),   (m_own >= 0) ? m_own : 0);
        chk("gnt_vld",  int'(gnt_vld),  (m_own >= 0) ? 1 : 0);
        chk("timeout",  int'(timeout),  m_to);
        chk("hold_cnt", int'(hold_cnt), m_cnt);
    endtask

    // Advance one clock with the inputs currently driven, then compare.
    task automatic step();
        if (!rst_b) model_reset();
        else model_update();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_b = 1'b0; req = '0; done = 1'b0;
        step(); step();
        rst_b = 1'b1;
    endtask

    initial begin
        int q[$];
        int n;
        rst_b = 1'b0; req = '0; done = 1'b0;
        model_reset();

        // Reset held with all requests active.
        req = 6'b111111;
        repeat (4) step();
        chk("rst_vld", int'(gnt_vld), 0);
        rst_b = 1'b1;

        // Two requesters alternate.
        do_reset();
        req = 6'b100100; done = 1'b1;
        q.delete();
        repeat (8) begin step(); if (gnt_vld) q.push_back(int'(gnt_id)); end
        chk("rot_n", q.size(), 4);
        if (q.size() == 4) begin
            chk("rot0", q[0], 2); chk("rot1", q[1], 5);
            chk("rot2", q[2], 2); chk("rot3", q[3], 5);
        end

        // Full rotation.
        do_reset();
        req = 6'b111111; done = 1'b1;
        q.delete();
        repeat (13) begin step(); if (gnt_vld) q.push_back(int'(gnt_id)); end
        chk("full_n", q.size(), 7);
        if (q.size() == 7)
            for (int i = 0; i < 7; i++) chk("full_id", q[i], i % 6);

        // Hold-limit timeout and regrant.
        do_reset();
        req = 6'b000001; done = 1'b0;
        step();
        n = 0;
        while (gnt_vld && n < 20) begin
            chk("to_cnt", int'(hold_cnt), n);
            n++;
            step();
        end
        chk("to_len", n, 8);
        chk("to_pulse", int'(timeout), 1);
        chk("to_vld0", int'(gnt_vld), 0);
        step();
        chk("to_regrant", int'(gnt_vld), 1);
        chk("to_regrant_id", int'(gnt_id), 0);
        chk("to_clear", int'(timeout), 0);

        // done / request drop on the final allowed cycle.
        do_reset();
        req = 6'b000001; done = 1'b0;
        repeat (8) step();
        chk("sim_cnt7", int'(hold_cnt), 7);
        done = 1'b1; step(); done = 1'b0;
        chk("sim_done_to", int'(timeout), 0);
        chk("sim_done_vld", int'(gnt_vld), 0);
        repeat (8) step();
        chk("sim2_cnt7", int'(hold_cnt), 7);
        req = 6'b000000; step();
        chk("sim_drop_to", int'(timeout), 0);
        chk("sim_drop_vld", int'(gnt_vld), 0);

        // Owner drops early, then asynchronous reset mid-grant.
        do_reset();
        req = 6'b001000;
        repeat (4) step();
        chk("drop_cnt3", int'(hold_cnt), 3);
        req = 6'b000000; step();
        chk("drop_vld", int'(gnt_vld), 0);
        chk("drop_to", int'(timeout), 0);
        req = 6'b001000; step(); step();
        chk("pre_rst_vld", int'(gnt_vld), 1);
        #2 rst_b = 1'b0;
        #1 model_reset();
        check_all();
        chk("async_gnt", int'(gnt), 0);
        #1 rst_b = 1'b1;
        req = 6'b100001; step();
        chk("post_rst_id", int'(gnt_id), 0);
        chk("post_rst_vld", int'(gnt_vld), 1);

        // Random traffic with sticky requests.
        do_reset();
        repeat (500) begin
            if ($urandom_range(0, 9) < 3) req = 6'($urandom_range(0, 63));
            done = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
